// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types, constants and address check for the instruction memory loader
package instr_mem_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      RUN   = 2'd1,
      PROG  = 2'd2
   } state_t;

   localparam logic [31:0] NOP_WORD = 32'hE1A00000;

   // True when a byte address is word-aligned and its word index lies below depth.
   function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth));
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - DEPTH x DATA_W storage, one synchronous write port, one registered read port
module instr_mem_array #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Only the read register is reset; the array itself is zeroed by the CLEAR sweep.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - instruction memory with clear-on-reset, programming port and 1-cycle fetch port
module instr_mem_loader
   import instr_mem_pkg::*;
#(
   parameter int                DEPTH      = 64,
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 32,
   parameter logic [DATA_W-1:0] FAULT_WORD = DATA_W'(NOP_WORD)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_en,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic              prog_err,
   output logic              busy,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_fault
);

   localparam int IDX_W = $clog2(DEPTH);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
         $error("instr_mem_loader: DEPTH must be a power of two >= 2");
      end
   endgenerate

   state_t              state;
   state_t              state_next;
   logic [IDX_W-1:0]    clr_cnt;
   logic                prog_ok;
   logic                fetch_ok;
   logic                fetch_acc;
   logic                mem_we;
   logic [IDX_W-1:0]    mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   rd_data;

   assign prog_ok     = addr_ok(64'(prog_addr), DEPTH);
   assign fetch_ok    = addr_ok(64'(fetch_addr), DEPTH);
   assign fetch_ready = (state == RUN) && !reset;
   assign busy        = !fetch_ready;
   assign fetch_acc   = fetch_req && fetch_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_next;
         clr_cnt <= (state == CLEAR) ? clr_cnt + IDX_W'(1) : '0;
      end
   end

   // Write port is owned by the clear sweep in CLEAR and by the programming interface in PROG.
   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      mem_waddr  = prog_addr[IDX_W+1:2];
      mem_wdata  = prog_data;
      case (state)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
            if (clr_cnt == IDX_W'(DEPTH - 1)) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (prog_en) begin
               state_next = PROG;
            end
         end
         PROG: begin
            mem_we = prog_we && prog_ok;
            if (!prog_en) begin
               state_next = RUN;
            end
         end
         default: state_next = CLEAR;
      endcase
      if (reset) begin
         mem_we = 1'b0;
      end
   end

   instr_mem_array #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (fetch_acc && fetch_ok),
      .raddr (fetch_addr[IDX_W+1:2]),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_valid <= 1'b0;
         fetch_fault <= 1'b0;
         prog_err    <= 1'b0;
      end else begin
         fetch_valid <= fetch_acc;
         if (fetch_acc) begin
            fetch_fault <= !fetch_ok;
         end
         prog_err <= (state == PROG) && prog_we && !prog_ok;
      end
   end

   // Faulted fetches skip the array read, so the held read word is masked here.
   assign fetch_data = fetch_fault ? FAULT_WORD : rd_data;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

   localparam int          DEPTH = 64;
   localparam logic [31:0] NOP   = 32'hE1A00000;

   logic        clk = 1'b0;
   logic        reset, prog_en, prog_we, fetch_req;
   logic [31:0] prog_addr, prog_data, fetch_addr;
   logic        prog_err, busy, fetch_ready, fetch_valid, fetch_fault;
   logic [31:0] fetch_data;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] e_data;
   logic        e_fault;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] exp_data;
      logic        exp_fault;
   } fvec_t;
   fvec_t tbl [10];

   always #5 clk = ~clk;

   instr_mem_loader dut (
      .clk         (clk),
      .reset       (reset),
      .prog_en     (prog_en),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_err    (prog_err),
      .busy        (busy),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .fetch_fault (fetch_fault)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit ref_ok(input logic [31:0] a);
      return (a % 4 == 0) && (a / 4 < DEPTH);
   endfunction

   task automatic ref_fetch(input logic [31:0] a);
      int idx;
      idx = int'(a / 4);
      if (ref_ok(a)) begin
         e_data  = ref_mem[idx];
         e_fault = 1'b0;
      end else begin
         e_data  = NOP;
         e_fault = 1'b1;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0:       return $urandom;
         1:       return $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
         2:       return 256 + $urandom_range(0, 63) * 4;
         default: return $urandom_range(0, 15) * 4;
      endcase
   endfunction

   task automatic fetch_one(input logic [31:0] a, input logic [31:0] d, input logic f, input string name);
      fetch_req  = 1'b1;
      fetch_addr = a;
      step();
      fetch_req = 1'b0;
      chk({name, " valid"}, fetch_valid, 1);
      chk({name, " data"}, fetch_data, d);
      chk({name, " fault"}, fetch_fault, f);
      e_data  = d;
      e_fault = f;
   endtask

   task automatic prog_write(input logic [31:0] a, input logic [31:0] d, input string name);
      int idx;
      idx       = int'(a / 4);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      step();
      prog_we = 1'b0;
      if (ref_ok(a)) ref_mem[idx] = d;
      chk({name, " prog_err"}, prog_err, !ref_ok(a));
   endtask

   task automatic wait_clear(input string name);
      int cnt;
      cnt = 0;
      #1;
      while (busy && cnt < 200) begin
         cnt++;
         step();
      end
      chk({name, " busy cycles"}, cnt, 64);
      chk({name, " fetch_ready"}, fetch_ready, 1);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          m_prog;
      bit          acc;
      logic [31:0] fa, pa, pd;
      logic        exp_err;
      int          pidx;

      tbl[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[1] = '{32'h0000_0004, 32'hE3A0_101E, 1'b0};
      tbl[2] = '{32'h0000_0008, 32'hE281_1001, 1'b0};
      tbl[3] = '{32'h0000_000C, 32'h0000_0000, 1'b0};
      tbl[4] = '{32'h0000_0006, NOP,           1'b1};
      tbl[5] = '{32'h0000_0100, NOP,           1'b1};
      tbl[6] = '{32'h0000_0102, NOP,           1'b1};
      tbl[7] = '{32'h0000_00FC, 32'h0000_0000, 1'b0};
      tbl[8] = '{32'h0000_0003, NOP,           1'b1};
      tbl[9] = '{32'h8000_0000, NOP,           1'b1};

      reset = 1'b1; prog_en = 1'b0; prog_we = 1'b0; fetch_req = 1'b0;
      prog_addr = '0; prog_data = '0; fetch_addr = '0;
      step();
      step();
      chk("reset busy", busy, 1);
      chk("reset fetch_ready", fetch_ready, 0);
      chk("reset fetch_valid", fetch_valid, 0);
      chk("reset fetch_data", fetch_data, 0);
      chk("reset fetch_fault", fetch_fault, 0);
      chk("reset prog_err", prog_err, 0);
      reset = 1'b0;
      wait_clear("clear0");
      fetch_one(32'h0, 32'h0, 1'b0, "first fetch");
      step();
      chk("idle valid", fetch_valid, 0);
      chk("idle data hold", fetch_data, 0);

      prog_en = 1'b1;
      step();
      chk("prog entry ready", fetch_ready, 0);
      chk("prog entry busy", busy, 1);
      prog_write(32'h04, 32'hE3A0101E, "wr04");
      prog_write(32'h08, 32'hE2811001, "wr08");
      prog_write(32'h102, 32'hDEADBEEF, "wr102");
      step();
      chk("prog_err pulse end", prog_err, 0);
      prog_write(32'h0E, 32'h55AA55AA, "wr0e misaligned");
      prog_en = 1'b0;
      step();
      chk("prog exit ready", fetch_ready, 1);
      prog_we = 1'b1; prog_addr = 32'h0C; prog_data = 32'h13572468;
      step();
      prog_we = 1'b0;
      chk("run write no err", prog_err, 0);

      fetch_req = 1'b1; fetch_addr = 32'h04;
      step();
      chk("b2b first valid", fetch_valid, 1);
      chk("b2b first data", fetch_data, 32'hE3A0101E);
      fetch_addr = 32'h08;
      step();
      chk("b2b second valid", fetch_valid, 1);
      chk("b2b second data", fetch_data, 32'hE2811001);
      fetch_req = 1'b0;
      step();
      chk("b2b after valid", fetch_valid, 0);
      chk("b2b after hold", fetch_data, 32'hE2811001);

      for (int i = 0; i < 10; i++) begin
         fetch_one(tbl[i].addr, tbl[i].exp_data, tbl[i].exp_fault, $sformatf("tbl%0d", i));
         step();
         chk($sformatf("tbl%0d idle valid", i), fetch_valid, 0);
         chk($sformatf("tbl%0d hold data", i), fetch_data, tbl[i].exp_data);
         chk($sformatf("tbl%0d hold fault", i), fetch_fault, tbl[i].exp_fault);
      end

      fetch_req = 1'b1; fetch_addr = 32'h04; prog_en = 1'b1;
      step();
      chk("fetch+prog_en valid", fetch_valid, 1);
      chk("fetch+prog_en data", fetch_data, 32'hE3A0101E);
      chk("fetch+prog_en ready", fetch_ready, 0);
      step();
      chk("fetch in prog ignored", fetch_valid, 0);
      chk("fetch in prog hold", fetch_data, 32'hE3A0101E);
      fetch_req = 1'b0; prog_en = 1'b0;
      step();
      e_data = 32'hE3A0101E; e_fault = 1'b0;

      m_prog = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 7) == 0) prog_en = ~prog_en;
         fa = rand_addr(); pa = rand_addr(); pd = $urandom;
         fetch_req = 1'($urandom_range(0, 1));
         prog_we   = 1'($urandom_range(0, 1));
         fetch_addr = fa; prog_addr = pa; prog_data = pd;
         acc = !m_prog && fetch_req;
         if (acc) ref_fetch(fa);
         exp_err = m_prog && prog_we && !ref_ok(pa);
         if (m_prog && prog_we && ref_ok(pa)) begin
            pidx = int'(pa / 4);
            ref_mem[pidx] = pd;
         end
         m_prog = prog_en;
         step();
         chk($sformatf("rnd%0d valid", c), fetch_valid, acc);
         chk($sformatf("rnd%0d data", c), fetch_data, e_data);
         chk($sformatf("rnd%0d fault", c), fetch_fault, e_fault);
         chk($sformatf("rnd%0d prog_err", c), prog_err, exp_err);
         chk($sformatf("rnd%0d ready", c), fetch_ready, !m_prog);
      end
      prog_en = 1'b0; prog_we = 1'b0; fetch_req = 1'b0;
      step();

      prog_en = 1'b1;
      step();
      prog_write(32'h10, 32'h12345678, "wr10");
      reset = 1'b1;
      step();
      step();
      chk("prog reset valid", fetch_valid, 0);
      chk("prog reset data", fetch_data, 0);
      chk("prog reset prog_err", prog_err, 0);
      reset = 1'b0; prog_en = 1'b0;
      repeat (10) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_clear("clear after mid-clear reset");
      fetch_one(32'h10, 32'h0, 1'b0, "wr10 cleared");

      reset = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h04;
      #1;
      chk("reset comb busy", busy, 1);
      chk("reset comb ready", fetch_ready, 0);
      step();
      chk("reset drops fetch", fetch_valid, 0);
      fetch_req = 1'b0; reset = 1'b0;
      wait_clear("clear final");
      fetch_one(32'h04, 32'h0, 1'b0, "wr04 cleared");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): DEPTH, 64, number of instruction words; DATA_W, 32, word width; ADDR_W, 32, byte-address width; FAULT_WORD, 32'hE1A00000, word returned on a faulted fetch (ARM NOP).
REQ-002 Ports SHALL be (name  direction  width  meaning): clk  in  1  the single clock; reset  in  1  synchronous, active-high reset.
REQ-003 prog_en  in  1  request programming mode; prog_we  in  1  write strobe; prog_addr  in  ADDR_W  byte address; prog_data  in  DATA_W  word to write.
REQ-004 prog_err  out  1  one-cycle pulse, rejected write; busy  out  1  memory is clearing or being programmed.
REQ-005 fetch_req  in  1  fetch request; fetch_addr  in  ADDR_W  byte address; fetch_ready  out  1  request accepted this cycle.
REQ-006 fetch_valid  out  1  response strobe; fetch_data  out  DATA_W  instruction; fetch_fault  out  1  response is a fault.

Function
REQ-007 The FSM SHALL have three states: CLEAR, RUN and PROG.
REQ-008 CLEAR SHALL write 0 to word index clr_cnt (0..DEPTH-1), one word per cycle; after index DEPTH-1 it SHALL enter RUN, so CLEAR lasts exactly DEPTH cycles.
REQ-009 In RUN, prog_en=1 SHALL move the FSM to PROG on the next cycle.
REQ-010 In PROG, prog_en=0 SHALL return the FSM to RUN on the next cycle; prog_en is ignored in CLEAR.
REQ-011 busy SHALL be 1 in CLEAR and PROG; fetch_ready SHALL equal (state==RUN).
REQ-012 A fetch is accepted when fetch_req && fetch_ready in cycle N; the response SHALL appear in cycle N+1 with fetch_valid=1 (fixed 1-cycle latency).
REQ-013 In cycles with no accepted fetch, the following cycle SHALL have fetch_valid=0; fetch_data and fetch_fault SHALL hold their last values.
REQ-014 A fetch faults when fetch_addr[1:0]!=0 or fetch_addr[ADDR_W-1:2]>=DEPTH; a faulted response SHALL give fetch_fault=1 and fetch_data=FAULT_WORD.
REQ-015 A non-faulted response SHALL give fetch_fault=0 and fetch_data=mem[fetch_addr[ADDR_W-1:2]].
REQ-016 In PROG, prog_we=1 with an aligned, in-range prog_addr SHALL write prog_data to word prog_addr>>2 at the clock edge.
REQ-017 Otherwise, prog_we=1 in PROG SHALL leave memory unchanged and pulse prog_err=1 in the next cycle.
REQ-018 prog_we outside PROG SHALL be ignored without prog_err.
REQ-019 When prog_en rises in the same RUN cycle as fetch_req, the fetch SHALL be accepted and answered normally, and PROG SHALL begin the cycle after.
REQ-020 A write followed by a fetch to the same word SHALL return the new data; there is no bypass path, because RUN and PROG are mutually exclusive.
REQ-021 Word index width SHALL be $clog2(DEPTH); DEPTH SHALL be a power of two >= 2, checked by an elaboration-time assertion.

Reset
REQ-022 While reset=1 at a clock edge: state SHALL become CLEAR, clr_cnt=0, fetch_valid=0, fetch_fault=0, fetch_data=0, prog_err=0.
REQ-023 During reset, busy SHALL be 1 and fetch_ready SHALL be 0.
REQ-024 Reset asserted mid-CLEAR or mid-PROG SHALL abandon the operation and restart CLEAR from index 0; a response pending at reset SHALL be dropped.
REQ-025 Memory contents are not reset directly; they SHALL be zeroed only by CLEAR.

Structure
REQ-026 Package instr_mem_pkg SHALL hold the state enum (CLEAR, RUN, PROG), the default NOP constant, and the alignment/range-check function.
REQ-027 Storage SHALL be in sub-module instr_mem_array: DEPTH x DATA_W, one synchronous write port, one registered read port.
REQ-028 The top level SHALL mux the write port between the CLEAR counter and the programming interface.

Verification
REQ-029 Reset, then idle: busy=1 for exactly 64 cycles after reset deasserts, then fetch_ready=1; fetch of 0x00 -> next cycle fetch_valid=1, fetch_data=0, fetch_fault=0.
REQ-030 Program 0xE3A0101E to 0x04 and 0xE2811001 to 0x08, then deassert prog_en: back-to-back fetches 0x04, 0x08 -> those words on consecutive cycles, fetch_valid held 1.
REQ-031 Fetch 0x06 and fetch 0x100 (DEPTH=64) -> fetch_fault=1, fetch_data=0xE1A00000 on each.
REQ-032 PROG write to 0x102 -> prog_err pulses for one cycle; a later fetch of 0x100 is still faulted and memory is unchanged.
REQ-033 Assert prog_en in the same cycle as fetch 0x04 -> response is delivered, and fetch_ready=0 from the next cycle.
REQ-034 Assert reset during PROG after one write, then wait for CLEAR -> fetch of the written address returns 0.
